// File: rtl/i2s_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// i2s_pkg : constants and sample type shared by the I2S transmitter/receiver
// Rev 1.0
// ---------------------------------------------------------------------------
package i2s_pkg;

  localparam int I2S_DATA_WIDTH = 24;
  localparam int I2S_SLOT_WIDTH = 32;
  localparam int I2S_CLK_DIV    = 4;

  typedef struct packed {
    logic signed [I2S_DATA_WIDTH-1:0] l;
    logic signed [I2S_DATA_WIDTH-1:0] r;
  } i2s_sample_t;

  // Counter width that stays legal when the count range is a single value.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/i2s_tx_clkgen_module.sv
`default_nettype none
// ---------------------------------------------------------------------------
// i2s_tx_clkgen_module : SCK divider with single-clock fall/rise strobes
// Rev 1.0
// ---------------------------------------------------------------------------
module i2s_tx_clkgen_module
  import i2s_pkg::*;
#(
  parameter int CLK_DIV = I2S_CLK_DIV
) (
  input  logic clk_i,
  input  logic rst_ni,
  output logic sck_o,
  output logic fall_o,
  output logic rise_o
);

  localparam int            DW       = cnt_width(CLK_DIV);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  logic [DW-1:0] div_cnt_q, div_cnt_d;
  logic          sck_q, sck_d;
  logic          wrap;

  always_comb begin
    wrap      = (div_cnt_q == DIV_LAST);
    div_cnt_d = wrap ? '0 : div_cnt_q + 1'b1;
    sck_d     = wrap ? ~sck_q : sck_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      div_cnt_q <= '0;
      sck_q     <= 1'b0;
    end else begin
      div_cnt_q <= div_cnt_d;
      sck_q     <= sck_d;
    end
  end

  // Strobes mark the clock whose edge will move SCK.
  assign fall_o = wrap & sck_q;
  assign rise_o = wrap & ~sck_q;
  assign sck_o  = sck_q;

endmodule
`default_nettype wire

// File: rtl/i2s_tx_module.sv
`default_nettype none
// ---------------------------------------------------------------------------
// i2s_tx_module : Philips I2S master transmitter with one-pair holding buffer
// Rev 1.0
// ---------------------------------------------------------------------------
module i2s_tx_module
  import i2s_pkg::*;
#(
  parameter int DATA_WIDTH = I2S_DATA_WIDTH,
  parameter int SLOT_WIDTH = I2S_SLOT_WIDTH,
  parameter int CLK_DIV    = I2S_CLK_DIV
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [DATA_WIDTH-1:0] left_i,
  input  logic [DATA_WIDTH-1:0] right_i,
  input  logic                  valid_i,
  output logic                  ready_o,
  output logic                  sck_o,
  output logic                  ws_o,
  output logic                  sd_o,
  output logic                  underrun_o
);

  localparam int            FRAME_BITS = 2 * SLOT_WIDTH;
  localparam int            KW         = cnt_width(FRAME_BITS);
  localparam int            PAD        = SLOT_WIDTH - DATA_WIDTH;
  localparam logic [KW-1:0] K_LAST     = KW'(FRAME_BITS - 1);
  localparam logic [KW-1:0] WS_FIRST   = KW'(SLOT_WIDTH - 1);
  localparam logic [KW-1:0] WS_LAST    = KW'(FRAME_BITS - 2);

  logic fall;
  logic unused_rise;

  i2s_tx_clkgen_module #(
    .CLK_DIV (CLK_DIV)
  ) u_clkgen (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .sck_o  (sck_o),
    .fall_o (fall),
    .rise_o (unused_rise)
  );

  logic [KW-1:0]         k_q, k_d;
  logic [FRAME_BITS-1:0] shift_q, shift_d, frame_w;
  logic [DATA_WIDTH-1:0] buf_l_q, buf_l_d, buf_r_q, buf_r_d;
  logic                  full_q, full_d;
  logic                  ws_q, ws_d;
  logic                  sd_q, sd_d;
  logic                  underrun_q, underrun_d;
  logic                  load, accept;

  always_comb begin
    load    = fall & (k_q == K_LAST);
    accept  = valid_i & ~full_q;
    // Each slot is MSB-aligned with zero padding below the sample.
    frame_w = full_q ? {SLOT_WIDTH'(buf_l_q) << PAD, SLOT_WIDTH'(buf_r_q) << PAD} : '0;

    k_d     = k_q;
    ws_d    = ws_q;
    sd_d    = sd_q;
    shift_d = shift_q;
    if (fall) begin
      k_d  = load ? '0 : k_q + 1'b1;
      ws_d = (k_d >= WS_FIRST) && (k_d <= WS_LAST);
      if (load) begin
        sd_d    = frame_w[FRAME_BITS-1];
        shift_d = frame_w << 1;
      end else begin
        sd_d    = shift_q[FRAME_BITS-1];
        shift_d = shift_q << 1;
      end
    end

    underrun_d = load & ~full_q;

    // A pair arriving on the load clock of an empty buffer waits a frame.
    full_d  = full_q;
    buf_l_d = buf_l_q;
    buf_r_d = buf_r_q;
    if (load && full_q) begin
      full_d  = 1'b0;
      buf_l_d = '0;
      buf_r_d = '0;
    end else if (accept) begin
      full_d  = 1'b1;
      buf_l_d = left_i;
      buf_r_d = right_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      k_q        <= K_LAST;
      shift_q    <= '0;
      buf_l_q    <= '0;
      buf_r_q    <= '0;
      full_q     <= 1'b0;
      ws_q       <= 1'b0;
      sd_q       <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      k_q        <= k_d;
      shift_q    <= shift_d;
      buf_l_q    <= buf_l_d;
      buf_r_q    <= buf_r_d;
      full_q     <= full_d;
      ws_q       <= ws_d;
      sd_q       <= sd_d;
      underrun_q <= underrun_d;
    end
  end

  assign ready_o    = ~full_q;
  assign ws_o       = ws_q;
  assign sd_o       = sd_q;
  assign underrun_o = underrun_q;

endmodule
`default_nettype wire

// File: tb/tb_i2s_tx_module.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_i2s_tx_module : self-checking bench for the I2S transmitter
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_i2s_tx_module;

  localparam int D  = 24;
  localparam int S  = 32;
  localparam int CD = 2;
  localparam int FB = 2 * S;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [D-1:0] left, right;
  logic         valid;
  logic         ready_o, sck_o, ws_o, sd_o, underrun_o;

  i2s_tx_module #(
    .DATA_WIDTH (D),
    .SLOT_WIDTH (S),
    .CLK_DIV    (CD)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .left_i     (left),
    .right_i    (right),
    .valid_i    (valid),
    .ready_o    (ready_o),
    .sck_o      (sck_o),
    .ws_o       (ws_o),
    .sd_o       (sd_o),
    .underrun_o (underrun_o)
  );

  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp_v);
    compared++;
    if (act !== exp_v) begin
      mismatched++;
      $display("FAIL %s at t=%0t: got %0h, expected %0h", nm, $time, act, exp_v);
    end
  endtask

  // Model: n counts clock edges since reset release; everything else follows
  // from frame arithmetic plus a one-entry buffer.
  int           n       = 0;
  bit           m_full  = 1'b0;
  logic [D-1:0] m_bl    = '0;
  logic [D-1:0] m_br    = '0;
  logic [63:0]  m_frame = '0;
  bit           m_urun  = 1'b0;
  bit           m_acc;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n = 0; m_full = 0; m_bl = '0; m_br = '0; m_frame = '0; m_urun = 0;
    end else begin
      m_acc  = valid && !m_full;
      n      = n + 1;
      m_urun = 0;
      if (n >= 2*CD && ((n - 2*CD) % (4*CD*S)) == 0) begin
        if (m_full) begin
          m_frame = {m_bl, 8'h00, m_br, 8'h00};
          m_full  = 0;
        end else begin
          m_frame = '0;
          m_urun  = 1;
        end
      end
      if (m_acc) begin
        m_bl = left; m_br = right; m_full = 1;
      end
    end
  end

  int          fc, kc;
  logic [63:0] cap        = '0;
  logic [63:0] last_frame = '0;
  int          urun_seen  = 0;
  int          urun_first = -1;
  int          ws_rise_k  = -1;
  int          ws_fall_k  = -1;
  logic        ws_prev    = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      ws_prev    = 1'b0;
      urun_first = -1;
    end else begin
      fc = n / (2*CD);
      kc = (fc == 0) ? FB - 1 : (fc - 1) % FB;
      chk("sck",      sck_o,      ((n / CD) % 2) == 1);
      chk("ws",       ws_o,       (kc >= S - 1) && (kc <= FB - 2));
      chk("sd",       sd_o,       m_frame[FB-1-kc]);
      chk("ready",    ready_o,    !m_full);
      chk("underrun", underrun_o, m_urun);
      if (n >= 2*CD && (n % (2*CD)) == 0) begin
        cap = {cap[62:0], sd_o};
        if (kc == FB - 1) last_frame = cap;
      end
      if (underrun_o) begin
        urun_seen++;
        if (urun_first < 0) urun_first = n;
      end
      if (ws_o && !ws_prev) ws_rise_k = kc;
      if (!ws_o && ws_prev) ws_fall_k = kc;
      ws_prev = ws_o;
    end
  end

  task automatic goto_n(input int t);
    int guard;
    guard = 0;
    while (n < t) begin
      @(negedge clk);
      guard++;
      if (guard > 20000) begin
        $display("FAIL goto_n timeout waiting for n=%0d, at n=%0d", t, n);
        $fatal(1, "bench stalled");
      end
    end
    #1;
  endtask

  int u0, accepts, bp_idx;
  bit pr;

  initial begin
    rst_n = 1'b0; valid = 1'b0; left = '0; right = '0;
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b1;

    // Reset and an empty first frame
    goto_n(1);   chk("lit_sck_n1", sck_o, 1'b0);
    goto_n(2);   chk("lit_sck_n2", sck_o, 1'b1);
    goto_n(4);   chk("lit_sck_n4", sck_o, 1'b0);
                 chk("lit_urun_n4", underrun_o, 1'b1);
    goto_n(5);   chk("lit_urun_n5", underrun_o, 1'b0);
    goto_n(260);
    chk("lit_first_urun_n", urun_first, 4);
    chk("lit_first_frame", last_frame, 64'h0);
    chk("lit_urun_count", urun_seen, 2);

    // Single frame loaded before the first load
    rst_n = 1'b0;
    @(negedge clk); @(negedge clk);
    #1 rst_n = 1'b1; left = 24'h800001; right = 24'h7FFFFE; valid = 1'b1;
    goto_n(1);   valid = 1'b0;
                 chk("lit_ready_after_accept", ready_o, 1'b0);
    goto_n(3);   chk("lit_ready_before_load", ready_o, 1'b0);
    goto_n(4);   chk("lit_ready_after_load", ready_o, 1'b1);
    goto_n(260);
    chk("lit_single_frame", last_frame, 64'h80000100_7FFFFE00);
    chk("lit_ws_rise_k", ws_rise_k, 31);
    chk("lit_ws_fall_k", ws_fall_k, 63);

    // Back-pressure: valid held high, incrementing pattern
    u0 = urun_seen; accepts = 0; bp_idx = 0;
    left = 24'h010000; right = 24'h020000; valid = 1'b1;
    pr = ready_o;
    while (n < 1028) begin
      @(negedge clk); #1;
      if (pr) begin
        accepts++; bp_idx++;
        left = 24'h010000 + D'(bp_idx); right = 24'h020000 + D'(bp_idx);
      end
      pr = ready_o;
    end
    valid = 1'b0;
    chk("lit_bp_accepts", accepts, 3);
    chk("lit_bp_no_underrun", urun_seen - u0, 0);

    // Underrun mid-stream
    u0 = urun_seen;
    goto_n(1284); chk("lit_bp_frame2", last_frame, 64'h01000200_02000200);
    goto_n(1290); left = 24'hA5A5A5; right = 24'h5A5A5A; valid = 1'b1;
    goto_n(1291); valid = 1'b0;
    goto_n(1540); chk("lit_underrun_frame", last_frame, 64'h0);
    goto_n(1541); chk("lit_underrun_once", urun_seen - u0, 1);
    goto_n(1796); chk("lit_after_underrun", last_frame, 64'hA5A5A500_5A5A5A00);

    // Valid presented exactly on the load clock with the buffer empty
    goto_n(2051); left = 24'h123456; right = 24'hFEDCBA; valid = 1'b1;
    goto_n(2052); valid = 1'b0;
                  chk("lit_simul_ready", ready_o, 1'b0);
                  chk("lit_simul_urun", underrun_o, 1'b1);
    goto_n(2308); chk("lit_simul_zero_frame", last_frame, 64'h0);
    goto_n(2564); chk("lit_simul_next_frame", last_frame, 64'h12345600_FEDCBA00);

    // Reset at k=40 with a pair pending in the buffer
    left = 24'h777777; right = 24'h888888; valid = 1'b1;
    goto_n(2565); valid = 1'b0;
    goto_n(2726);
    chk("lit_pre_rst_sck", sck_o, 1'b1);
    chk("lit_pre_rst_ws", ws_o, 1'b1);
    chk("lit_pre_rst_ready", ready_o, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("lit_rst_sck", sck_o, 1'b0);
    chk("lit_rst_ws", ws_o, 1'b0);
    chk("lit_rst_sd", sd_o, 1'b0);
    chk("lit_rst_ready", ready_o, 1'b1);
    chk("lit_rst_urun", underrun_o, 1'b0);
    @(negedge clk); @(negedge clk);
    #1 rst_n = 1'b1;
    goto_n(1);   chk("lit_post_rst_ready", ready_o, 1'b1);
    goto_n(260); chk("lit_post_rst_frame", last_frame, 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
`default_nettype wire
